sum_rest_arb: RTL and testbench
===============================

# sum_rest_arb

- Two-requester controller that shares one 4-bit adder/subtractor unit.
- Accepts add/sub requests on a req/ack handshake and arbitrates between them round-robin.
- Drives the unit's select and operand inputs, waits out the unit's latency, captures its 5-bit result and returns it with a one-cycle acknowledge.
- Sits between the two client blocks and the shared arithmetic unit.

## Interface
- LAT, default 1: registered latency of the shared unit in clock edges (≥1).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req0, req1  in  1  request from requester 0/1; level, held until ack.
- op0, op1  in  1  operation per requester: 1 = add, 0 = subtract.
- a0, b0, a1, b1  in  4 each  operands per requester; stable while req high.
- ack0, ack1  out  1  one-cycle pulse: result on res belongs to this requester.
- res  out  5  captured result; holds until the next capture.
- busy  out  1  high whenever state ≠ IDLE.
- u_sel  out  1  select to the unit (1 = add, 0 = subtract).
- u_ent1, u_ent2  out  4 each  operands to the unit.
- u_sal  in  5  result from the unit.

## Operation
- Shared unit contract:
  - Add: u_sal = u_ent1 + u_ent2, zero-extended to 5 bits.
  - Subtract: u_sal = (u_ent1 − u_ent2) mod 32, i.e. 5-bit two's complement.
  - Valid LAT edges after its inputs change.
- res is passed through verbatim from u_sal; no arithmetic is done in this block.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: samples req0/req1 every edge.
    - If any is high, choose a winner, register its op/a/b into u_sel/u_ent1/u_ent2, record the owner, go to ISSUE.
    - If none is high, stay in IDLE.
  - ISSUE: 1 cycle; u_* held; go to WAIT and load the wait counter with LAT−1.
  - WAIT: holds u_*, lasts exactly LAT cycles. On its final edge, res ← u_sal, the owner's ack goes high, go to DONE.
  - DONE: 1 cycle with ack high; then go to IDLE and clear ack.
- Arbitration:
  - A priority pointer selects the preferred requester. After reset it prefers requester 0.
  - Only one requester high: it wins regardless of the pointer.
  - Both high: the pointer's requester wins.
  - On every grant the pointer moves to the non-winning requester.
- Handshake:
  - A requester keeps req and its operands stable from req rise until it samples its ack high.
  - It deasserts req on the same edge it samples ack.
  - A req still high in IDLE after DONE is a new request; this is legal back-to-back use.
- Requests arriving while busy are not lost. They are seen in the next IDLE cycle.
- u_* are never changed outside IDLE→ISSUE.

## Timing
- Reset (rst_n low at an edge):
  - state = IDLE, pointer = 0.
  - ack0 = ack1 = 0, res = 0, busy = 0, u_sel = 0, u_ent1 = u_ent2 = 0.
- Reset in any state, including mid-operation, aborts the transaction: no ack is issued and res returns to 0.
- Request sampled high at edge k (state IDLE):
  - ISSUE during k..k+1.
  - WAIT during k+1..k+1+LAT.
  - res updated and ack high from edge k+1+LAT, for exactly one cycle.
  - IDLE again from edge k+2+LAT.
- Throughput: one operation per LAT+3 cycles with requests continuously pending.
- busy rises at edge k and falls at edge k+2+LAT.
- ack0 and ack1 are never high together. Exactly one ack per grant.
- The wait counter is ⌈log2(LAT)⌉+1 bits wide and saturates at 0 outside WAIT.

## Test plan
- Reset, then pulse req0 with op0 = 1, a0 = 7, b0 = 8 (LAT = 1) -> u_sel = 1, u_ent1 = 7, u_ent2 = 8 from edge k; ack0 at edge k+2; res = 15; ack1 stays 0.
- req1 with op1 = 1, a1 = 15, b1 = 15 -> res = 30 (5'b11110) with ack1; then op1 = 0, a1 = 15, b1 = 0 -> res = 15.
- req0 with op0 = 0, a0 = 3, b0 = 5 -> res = 30 (5'b11110, −2 mod 32); u_sel = 0 throughout ISSUE/WAIT.
- req0 and req1 both high from the same edge after reset, both held until their acks:
  - requester 0 is served first, requester 1 second, then requester 0 again.
  - acks strictly alternate.
  - busy low for exactly one cycle between operations.
- Assert rst_n low during WAIT of a req0 transaction -> no ack0; res = 0, busy = 0 next cycle; re-issued req0 with a0 = 1, b0 = 2 (add) completes with res = 3.
- Rebuild with LAT = 3; req0 add 9+6 -> ack0 exactly 4 edges after the sampling edge; res = 15; u_* stable for all 4 cycles.

Source files
------------

// File: rtl/sum_rest_arb.sv
// Two-requester round-robin front end for a shared 4-bit add/subtract unit with
// LAT-cycle registered latency; returns the unit's 5-bit result with a one-cycle ack.
module sum_rest_arb #(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       op0,
  input  logic       op1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       ack0,
  output logic       ack1,
  output logic [4:0] res,
  output logic       busy,
  output logic       u_sel,
  output logic [3:0] u_ent1,
  output logic [3:0] u_ent2,
  input  logic [4:0] u_sal
);

  localparam int CW = $clog2(LAT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          ptr;
  logic          owner;
  logic          take;
  logic          grant;

  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order in which processes run.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    take  = (state == IDLE) && (req0 || req1);
    grant = (req0 && req1) ? ptr : req1;
  end

  // NOTE: assigning a default before the case keeps this block latch-free.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    ack0 = (state == DONE) && !owner;
    ack1 = (state == DONE) &&  owner;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= 1'b0;
      owner    <= 1'b0;
      u_sel    <= 1'b0;
      u_ent1   <= '0;
      u_ent2   <= '0;
      res      <= '0;
      wait_cnt <= '0;
    end else begin
      if (take) begin
        owner  <= grant;
        ptr    <= ~grant;
        u_sel  <= grant ? op1 : op0;
        u_ent1 <= grant ? a1 : a0;
        u_ent2 <= grant ? b1 : b0;
      end
      // Counter is only meaningful in WAIT; it rests at zero everywhere else.
      if (state == ISSUE)                         wait_cnt <= CW'(LAT - 1);
      else if (state == WAIT && wait_cnt != '0)   wait_cnt <= wait_cnt - 1'b1;
      else                                        wait_cnt <= '0;
      if (state == WAIT && wait_cnt == '0) res <= u_sal;
    end
  end

endmodule

// File: tb/tb_sum_rest_arb.sv
// Bench for sum_rest_arb: two instances (LAT=1 and LAT=3), each with a behavioural
// shared-unit model, compared every cycle against a transaction-level reference.
module tb_sum_rest_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Index [d] selects the instance, [r] the requester.
  logic       req    [2][2];
  logic       op     [2][2];
  logic [3:0] a      [2][2];
  logic [3:0] b      [2][2];
  logic       ack    [2][2];
  logic [4:0] res    [2];
  logic       busy   [2];
  logic       u_sel  [2];
  logic [3:0] u_ent1 [2];
  logic [3:0] u_ent2 [2];
  logic [4:0] u_sal  [2];

  int n_checks = 0;
  int n_fail   = 0;

  sum_rest_arb #(.LAT(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .req0(req[0][0]), .req1(req[0][1]), .op0(op[0][0]), .op1(op[0][1]),
    .a0(a[0][0]), .b0(b[0][0]), .a1(a[0][1]), .b1(b[0][1]),
    .ack0(ack[0][0]), .ack1(ack[0][1]), .res(res[0]), .busy(busy[0]),
    .u_sel(u_sel[0]), .u_ent1(u_ent1[0]), .u_ent2(u_ent2[0]), .u_sal(u_sal[0])
  );

  sum_rest_arb #(.LAT(3)) dut_l3 (
    .clk(clk), .rst_n(rst_n),
    .req0(req[1][0]), .req1(req[1][1]), .op0(op[1][0]), .op1(op[1][1]),
    .a0(a[1][0]), .b0(b[1][0]), .a1(a[1][1]), .b1(b[1][1]),
    .ack0(ack[1][0]), .ack1(ack[1][1]), .res(res[1]), .busy(busy[1]),
    .u_sel(u_sel[1]), .u_ent1(u_ent1[1]), .u_ent2(u_ent2[1]), .u_sal(u_sal[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Shared arithmetic unit: a plain pipeline, tapped at LAT stages.
  function automatic logic [4:0] unit_f(input logic s, input logic [3:0] x, input logic [3:0] y);
    return s ? ({1'b0, x} + {1'b0, y}) : ({1'b0, x} - {1'b0, y});
  endfunction

  logic [4:0] pipe [2][3];
  always_ff @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      pipe[d][0] <= unit_f(u_sel[d], u_ent1[d], u_ent2[d]);
      pipe[d][1] <= pipe[d][0];
      pipe[d][2] <= pipe[d][1];
    end
  end
  assign u_sal[0] = pipe[0][0];
  assign u_sal[1] = pipe[1][2];

  // Reference model: one transaction in flight, timed in edges since the grant.
  bit       m_active [2];
  int       m_ptr    [2];
  int       m_owner  [2];
  int       m_cyc    [2];
  bit       m_ack    [2][2];
  bit       m_sel    [2];
  bit [3:0] m_e1     [2];
  bit [3:0] m_e2     [2];
  bit [4:0] m_res    [2];
  bit [4:0] m_result [2];

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_active[d] = 1'b0; m_ptr[d] = 0; m_cyc[d] = 0;
        m_ack[d][0] = 1'b0; m_ack[d][1] = 1'b0;
        m_res[d] = '0; m_sel[d] = 1'b0; m_e1[d] = '0; m_e2[d] = '0;
      end else if (m_active[d]) begin
        m_cyc[d]++;
        if (m_cyc[d] == lat_of(d) + 1) begin
          m_res[d] = m_result[d];
          m_ack[d][m_owner[d]] = 1'b1;
        end else if (m_cyc[d] == lat_of(d) + 2) begin
          m_active[d] = 1'b0;
          m_ack[d][0] = 1'b0; m_ack[d][1] = 1'b0;
        end
      end else if (req[d][0] || req[d][1]) begin
        int w;
        if (req[d][0] && req[d][1]) w = m_ptr[d];
        else                        w = req[d][1] ? 1 : 0;
        m_ptr[d]    = 1 - w;
        m_owner[d]  = w;
        m_active[d] = 1'b1;
        m_cyc[d]    = 0;
        m_sel[d]    = op[d][w];
        m_e1[d]     = a[d][w];
        m_e2[d]     = b[d][w];
        m_result[d] = op[d][w] ? 5'(int'(a[d][w]) + int'(b[d][w]))
                               : 5'((32 + int'(a[d][w]) - int'(b[d][w])) % 32);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_ack0", d),   32'(ack[d][0]), 32'(m_ack[d][0]));
      check($sformatf("d%0d_ack1", d),   32'(ack[d][1]), 32'(m_ack[d][1]));
      check($sformatf("d%0d_busy", d),   32'(busy[d]),   32'(m_active[d]));
      check($sformatf("d%0d_res", d),    32'(res[d]),    32'(m_res[d]));
      check($sformatf("d%0d_u_sel", d),  32'(u_sel[d]),  32'(m_sel[d]));
      check($sformatf("d%0d_u_ent1", d), 32'(u_ent1[d]), 32'(m_e1[d]));
      check($sformatf("d%0d_u_ent2", d), 32'(u_ent2[d]), 32'(m_e2[d]));
      check($sformatf("d%0d_ack_excl", d), 32'(ack[d][0] & ack[d][1]), 32'd0);
    end
  endtask

  // One clock: advance the model at the edge, compare at the falling edge, and
  // let each requester drop req once it has seen its ack.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 2; r++)
        if (ack[d][r]) req[d][r] = 1'b0;
  endtask

  task automatic run_op(input int d, input int r, input logic o, input logic [3:0] x,
                        input logic [3:0] y, input logic [4:0] exp_res);
    int n;
    bit seen;
    op[d][r] = o; a[d][r] = x; b[d][r] = y; req[d][r] = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      cycle();
      n++;
      seen = ack[d][r];
    end
    // Edges from the sampling edge to the ack edge must equal LAT+1.
    check($sformatf("d%0d_r%0d_ack_latency", d, r), 32'(n - 1), 32'(lat_of(d) + 1));
    check($sformatf("d%0d_r%0d_res", d, r), 32'(res[d]), 32'(exp_res));
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    int gaps[$];
    int idle_run;
    bit rearmed;

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 2; r++) begin
        req[d][r] = 1'b0; op[d][r] = 1'b0; a[d][r] = '0; b[d][r] = '0;
      end

    cycle();
    cycle();
    check("reset_busy", 32'(busy[0]), 32'd0);
    check("reset_res", 32'(res[0]), 32'd0);
    check("reset_u_ent1", 32'(u_ent1[0]), 32'd0);
    rst_n = 1'b1;
    cycle();

    run_op(0, 0, 1'b1, 4'd7,  4'd8,  5'd15);
    run_op(0, 1, 1'b1, 4'd15, 4'd15, 5'd30);
    run_op(0, 1, 1'b0, 4'd15, 4'd0,  5'd15);
    run_op(0, 0, 1'b0, 4'd3,  4'd5,  5'd30);

    // Both requesters from the same edge right after reset.
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    for (int r = 0; r < 2; r++) begin
      op[0][r] = 1'($urandom_range(0, 1));
      a[0][r]  = 4'($urandom_range(0, 15));
      b[0][r]  = 4'($urandom_range(0, 15));
      req[0][r] = 1'b1;
    end
    idle_run = 0;
    rearmed = 1'b0;
    for (int i = 0; i < 40 && order.size() < 3; i++) begin
      cycle();
      if (!busy[0]) idle_run++;
      if (ack[0][0] || ack[0][1]) begin
        order.push_back(ack[0][1] ? 1 : 0);
        if (order.size() > 1) gaps.push_back(idle_run);
        idle_run = 0;
        if (ack[0][0] && !rearmed) begin
          rearmed = 1'b1;
          a[0][0] = 4'($urandom_range(0, 15));
          b[0][0] = 4'($urandom_range(0, 15));
          req[0][0] = 1'b1;
        end
      end
    end
    check("rr_ack_count", 32'(order.size()), 32'd3);
    if (order.size() == 3) begin
      check("rr_first",  32'(order[0]), 32'd0);
      check("rr_second", 32'(order[1]), 32'd1);
      check("rr_third",  32'(order[2]), 32'd0);
      check("rr_gap0", 32'(gaps[0]), 32'd1);
      check("rr_gap1", 32'(gaps[1]), 32'd1);
    end
    cycle();
    cycle();

    // Reset in the middle of WAIT aborts the transaction.
    op[0][0] = 1'b1; a[0][0] = 4'd5; b[0][0] = 4'd5; req[0][0] = 1'b1;
    cycle();
    cycle();
    check("abort_busy_before", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    req[0][0] = 1'b0;
    cycle();
    check("abort_ack0", 32'(ack[0][0]), 32'd0);
    check("abort_res",  32'(res[0]), 32'd0);
    check("abort_busy", 32'(busy[0]), 32'd0);
    rst_n = 1'b1;
    cycle();
    run_op(0, 0, 1'b1, 4'd1, 4'd2, 5'd3);

    run_op(1, 0, 1'b1, 4'd9, 4'd6, 5'd15);

    // Random traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      for (int d = 0; d < 2; d++)
        for (int r = 0; r < 2; r++)
          if (!req[d][r] && $urandom_range(0, 3) == 0) begin
            op[d][r]  = 1'($urandom_range(0, 1));
            a[d][r]   = 4'($urandom_range(0, 15));
            b[d][r]   = 4'($urandom_range(0, 15));
            req[d][r] = 1'b1;
          end
      cycle();
    end
    for (int i = 0; i < 30; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
